// File: rtl/traffic_pkg.sv
// traffic_pkg: state encoding, LFSR tap masks and counter width shared by the traffic generator
package traffic_pkg;
  typedef enum logic {IDLE, SEND} state_t;
  localparam int CNT_W = 16;
  function automatic logic [31:0] tap_mask(input int w);
    return w == 8 ? 32'h0000_00B8 : w == 16 ? 32'h0000_D008 : 32'h8020_0003;
  endfunction
endpackage

// File: rtl/traffic_lfsr.sv
// traffic_lfsr: Fibonacci XNOR LFSR, left shift with feedback into bit 0, loadable seed
module traffic_lfsr
  import traffic_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         load,
  input  logic [W-1:0] seed,
  output logic [W-1:0] out
);
  localparam logic [31:0] TAPS = tap_mask(W);
  localparam logic [W-1:0] MASK = TAPS[W-1:0];
  // reset beats load beats shift; an all-ones seed is the XNOR lock-up state so it loads as zero
  always_ff @(posedge clk)
    out <= reset ? '0 : load ? (&seed ? '0 : seed) : enable ? {out[W-2:0], ~^(out & MASK)} : out;
endmodule

// File: rtl/traffic_gen.sv
// traffic_gen: LFSR-driven packet injector emitting head/body/tail flits over valid/ready
module traffic_gen
  import traffic_pkg::*;
#(
  parameter int LFSR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int NODE_W  = 4,
  parameter int SRC_ID  = 0,
  parameter int PKT_LEN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic [7:0]        rate,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic [DATA_W-1:0] flit_data,
  output logic              flit_head,
  output logic              flit_tail,
  output logic [CNT_W-1:0]  pkt_count
);
  localparam int IW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;
  localparam int REM = DATA_W - 2 * NODE_W;
  localparam logic [IW-1:0] LAST = IW'(PKT_LEN - 1);
  localparam logic [NODE_W-1:0] SRC = NODE_W'(SRC_ID);
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [NODE_W-1:0] dest, dest_n;
  logic [DATA_W-1:0] body, body_n;
  logic [CNT_W-1:0] cnt_n;
  logic [LFSR_W-1:0] lfsr;
  logic start, xfer, last;
  traffic_lfsr #(.W(LFSR_W)) u_lfsr (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .load(seed_load),
    .seed(seed),
    .out(lfsr)
  );
  assign flit_valid = state == SEND;
  assign flit_head = flit_valid && idx == '0;
  assign flit_tail = flit_valid && idx == LAST;
  assign flit_data = !flit_valid ? '0 : idx == '0 ? {dest, SRC, REM'(pkt_count)} : body;
  // start on an injection hit, step the index per transfer, close the packet on the tail transfer
  always_comb begin
    start = state == IDLE && enable && (rate == 8'hFF || lfsr[7:0] < rate);
    xfer = flit_valid && flit_ready;
    last = xfer && flit_tail;
    state_n = start ? SEND : last ? IDLE : state;
    idx_n = start || last ? '0 : xfer ? idx + 1'b1 : idx;
    dest_n = start ? lfsr[NODE_W-1:0] : dest;
    body_n = xfer ? DATA_W'(lfsr) : body;
    cnt_n = last ? pkt_count + 1'b1 : pkt_count;
  end
  // state register; reset abandons any packet in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      dest <= '0;
      body <= '0;
      pkt_count <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      dest <= dest_n;
      body <= body_n;
      pkt_count <= cnt_n;
    end
  end
endmodule
